// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
//   Shared types and constants for the MEM / MEM-WB stage of the 16-bit CPU:
//   the access FSM state encoding, the default UART status address and a
//   helper that packs the UART status word returned by a status load.
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

    // Access FSM states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ADDR  = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR_ADDR  = 3'd3,
        ST_WR_PULSE = 3'd4
    } state_t;

    // Memory-mapped UART status word address
    localparam logic [15:0] DEFAULT_STATUS_ADDR = 16'hBF01;

    // Status word layout: bit 1 = receive data ready, bit 0 = transmit buffer empty
    function automatic logic [15:0] status_word(input logic data_ready, input logic tbre);
        status_word = {14'b0, data_ready, tbre};
    endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM stage plus MEM/WB pipeline register. Loads and stores go to the
//   external asynchronous SRAM through a small multi-cycle FSM; a load from
//   STATUS_ADDR returns the UART status word without touching the SRAM, and a
//   store there is dropped. Upstream stages are stalled while an SRAM access
//   is in flight. The registered write-back triple drives the register file.
//
// Ports
//   i_clk               clock, all state on posedge
//   i_rst               synchronous active-high reset
//   i_mem_re / i_mem_we load / store request from EX/MEM
//   i_mem_addr          16-bit data address
//   i_mem_wdata         store data
//   i_alu_result        write-back data for non-memory instructions
//   i_reg_addr          destination register
//   i_reg_we            destination write enable
//   i_uart_data_ready   status bit 1
//   i_uart_tbre         status bit 0
//   i_ram_data          SRAM read data
//   o_ram_addr          SRAM address (zero-extended memAddr)
//   o_ram_wdata         SRAM write data
//   o_ram_ce_n/oe_n/we_n active-low SRAM strobes
//   o_stall_req         hold IF/ID/EX and EX/MEM this cycle
//   o_wb_data/addr/we   register file write port
// ---------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int          RAM_AW      = 18,
    parameter logic [15:0] STATUS_ADDR = DEFAULT_STATUS_ADDR,
    parameter int          WAIT_CYC    = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mem_re,
    input  logic              i_mem_we,
    input  logic [15:0]       i_mem_addr,
    input  logic [15:0]       i_mem_wdata,
    input  logic [15:0]       i_alu_result,
    input  logic [3:0]        i_reg_addr,
    input  logic              i_reg_we,
    input  logic              i_uart_data_ready,
    input  logic              i_uart_tbre,
    input  logic [15:0]       i_ram_data,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [15:0]       o_ram_wdata,
    output logic              o_ram_ce_n,
    output logic              o_ram_oe_n,
    output logic              o_ram_we_n,
    output logic              o_stall_req,
    output logic [15:0]       o_wb_data,
    output logic [3:0]        o_wb_addr,
    output logic              o_wb_we
);

    localparam logic [2:0] WAIT_LIM = 3'(WAIT_CYC);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [RAM_AW-1:0] r_ram_addr;
    logic [15:0]       r_ram_wdata;
    logic [15:0]       r_wb_data;
    logic [3:0]        r_wb_addr;
    logic              r_wb_we;

    logic [RAM_AW-1:0] w_addr_ext;
    logic              w_is_status;
    logic              w_ce_n;
    logic              w_oe_n;
    logic              w_we_n;
    logic              w_stall;

    // Address is zero-extended only; no wrap into the upper SRAM space
    assign w_addr_ext  = {{(RAM_AW-16){1'b0}}, i_mem_addr};
    assign w_is_status = (i_mem_addr == STATUS_ADDR);

    // Strobe decode from the state register alone so they never glitch on input changes
    always_comb begin
        w_ce_n = 1'b1;
        w_oe_n = 1'b1;
        w_we_n = 1'b1;
        case (r_state)
            ST_RD_ADDR, ST_RD_DATA: begin
                w_ce_n = 1'b0;
                w_oe_n = 1'b0;
            end
            ST_WR_ADDR: begin
                w_ce_n = 1'b0;
            end
            ST_WR_PULSE: begin
                w_ce_n = 1'b0;
                w_we_n = 1'b0;
            end
            default: begin
                w_ce_n = 1'b1;
                w_oe_n = 1'b1;
                w_we_n = 1'b1;
            end
        endcase
    end

    // Stall decode: released in RD_DATA / WR_PULSE so EX/MEM advances on the final edge
    // and the same request is not issued twice
    always_comb begin
        w_stall = 1'b0;
        if (i_rst) begin
            w_stall = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:    w_stall = (i_mem_re | i_mem_we) & ~w_is_status;
                ST_RD_ADDR: w_stall = 1'b1;
                ST_WR_ADDR: w_stall = 1'b1;
                default:    w_stall = 1'b0;
            endcase
        end
    end

    // Access FSM, wait counter, SRAM address/data latches and MEM/WB register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 16'h0000;
            r_wb_data   <= 16'h0000;
            r_wb_addr   <= 4'd0;
            r_wb_we     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_mem_we) begin
                        // Store wins over a simultaneous load; status store is a bubble
                        r_wb_we <= 1'b0;
                        if (!w_is_status) begin
                            r_ram_addr  <= w_addr_ext;
                            r_ram_wdata <= i_mem_wdata;
                            r_state     <= ST_WR_ADDR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (i_mem_re) begin
                        if (w_is_status) begin
                            r_wb_data <= status_word(i_uart_data_ready, i_uart_tbre);
                            r_wb_addr <= i_reg_addr;
                            r_wb_we   <= i_reg_we;
                        end else begin
                            r_ram_addr <= w_addr_ext;
                            r_wb_we    <= 1'b0;
                            r_state    <= ST_RD_ADDR;
                        end
                    end else begin
                        r_wb_data <= i_alu_result;
                        r_wb_addr <= i_reg_addr;
                        r_wb_we   <= i_reg_we;
                    end
                end
                ST_RD_ADDR: begin
                    r_wb_we <= 1'b0;
                    if (r_cnt < WAIT_LIM) begin
                        r_cnt <= r_cnt + 3'd1;
                    end else begin
                        r_cnt   <= 3'd0;
                        r_state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    r_wb_data <= i_ram_data;
                    r_wb_addr <= i_reg_addr;
                    r_wb_we   <= i_reg_we;
                    r_state   <= ST_IDLE;
                end
                ST_WR_ADDR: begin
                    r_wb_we <= 1'b0;
                    if (r_cnt < WAIT_LIM) begin
                        r_cnt <= r_cnt + 3'd1;
                    end else begin
                        r_cnt   <= 3'd0;
                        r_state <= ST_WR_PULSE;
                    end
                end
                ST_WR_PULSE: begin
                    r_wb_we <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 3'd0;
                    r_wb_we <= 1'b0;
                end
            endcase
        end
    end

    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_ram_ce_n  = w_ce_n;
    assign o_ram_oe_n  = w_oe_n;
    assign o_ram_we_n  = w_we_n;
    assign o_stall_req = w_stall;
    assign o_wb_data   = r_wb_data;
    assign o_wb_addr   = r_wb_addr;
    assign o_wb_we     = r_wb_we;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Directed bench for mem_wb_stage. Two instances share the stimulus: d0 with
//   WAIT_CYC=0 and d3 with WAIT_CYC=3. Inputs change 1 time unit after each
//   rising edge; outputs are sampled there or 1 unit later.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] alu_result;
    logic [3:0]  reg_addr;
    logic        reg_we;
    logic        uart_dr;
    logic        uart_tbre;
    logic [15:0] ram_data;

    logic [17:0] d0_ram_addr, d3_ram_addr;
    logic [15:0] d0_ram_wdata, d3_ram_wdata;
    logic        d0_ce_n, d0_oe_n, d0_we_n, d3_ce_n, d3_oe_n, d3_we_n;
    logic        d0_stall, d3_stall;
    logic [15:0] d0_wb_data, d3_wb_data;
    logic [3:0]  d0_wb_addr, d3_wb_addr;
    logic        d0_wb_we, d3_wb_we;

    int errors = 0;
    int checks = 0;

    mem_wb_stage #(.RAM_AW(18), .STATUS_ADDR(16'hBF01), .WAIT_CYC(0)) d0 (
        .i_clk(clk), .i_rst(rst), .i_mem_re(mem_re), .i_mem_we(mem_we),
        .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata), .i_alu_result(alu_result),
        .i_reg_addr(reg_addr), .i_reg_we(reg_we), .i_uart_data_ready(uart_dr),
        .i_uart_tbre(uart_tbre), .i_ram_data(ram_data),
        .o_ram_addr(d0_ram_addr), .o_ram_wdata(d0_ram_wdata),
        .o_ram_ce_n(d0_ce_n), .o_ram_oe_n(d0_oe_n), .o_ram_we_n(d0_we_n),
        .o_stall_req(d0_stall), .o_wb_data(d0_wb_data), .o_wb_addr(d0_wb_addr),
        .o_wb_we(d0_wb_we)
    );

    mem_wb_stage #(.RAM_AW(18), .STATUS_ADDR(16'hBF01), .WAIT_CYC(3)) d3 (
        .i_clk(clk), .i_rst(rst), .i_mem_re(mem_re), .i_mem_we(mem_we),
        .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata), .i_alu_result(alu_result),
        .i_reg_addr(reg_addr), .i_reg_we(reg_we), .i_uart_data_ready(uart_dr),
        .i_uart_tbre(uart_tbre), .i_ram_data(ram_data),
        .o_ram_addr(d3_ram_addr), .o_ram_wdata(d3_ram_wdata),
        .o_ram_ce_n(d3_ce_n), .o_ram_oe_n(d3_oe_n), .o_ram_we_n(d3_we_n),
        .o_stall_req(d3_stall), .o_wb_data(d3_wb_data), .o_wb_addr(d3_wb_addr),
        .o_wb_we(d3_wb_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_re = 1'b1; mem_we = 1'b0; mem_addr = 16'h0040;
        mem_wdata = 16'h0000; alu_result = 16'h0000; reg_addr = 4'd0; reg_we = 1'b0;
        uart_dr = 1'b0; uart_tbre = 1'b0; ram_data = 16'h0000;

        // 1. reset held for two edges with a load request pending
        tick(); tick();
        chk("rst_ce", {31'd0, d0_ce_n}, 32'd1);
        chk("rst_oe", {31'd0, d0_oe_n}, 32'd1);
        chk("rst_we_n", {31'd0, d0_we_n}, 32'd1);
        chk("rst_wbwe", {31'd0, d0_wb_we}, 32'd0);
        chk("rst_stall", {31'd0, d0_stall}, 32'd0);
        chk("rst_ramaddr", {14'd0, d0_ram_addr}, 32'd0);
        chk("rst_wbdata", {16'd0, d0_wb_data}, 32'd0);
        chk("rst_d3_ce", {31'd0, d3_ce_n}, 32'd1);

        // 2. plain ALU write-back
        rst = 1'b0; mem_re = 1'b0;
        alu_result = 16'h1234; reg_addr = 4'd3; reg_we = 1'b1;
        #1 chk("alu_stall_pre", {31'd0, d0_stall}, 32'd0);
        tick();
        chk("alu_wbdata", {16'd0, d0_wb_data}, 32'h1234);
        chk("alu_wbaddr", {28'd0, d0_wb_addr}, 32'd3);
        chk("alu_wbwe", {31'd0, d0_wb_we}, 32'd1);
        chk("alu_stall", {31'd0, d0_stall}, 32'd0);

        // 3. SRAM load, no wait states
        mem_re = 1'b1; mem_addr = 16'h0040; ram_data = 16'hBEEF;
        reg_addr = 4'd5; alu_result = 16'h7777;
        #1 chk("ld_idle_stall", {31'd0, d0_stall}, 32'd1);
        chk("ld_idle_oe", {31'd0, d0_oe_n}, 32'd1);
        tick();
        chk("ld_a_stall", {31'd0, d0_stall}, 32'd1);
        chk("ld_a_oe", {31'd0, d0_oe_n}, 32'd0);
        chk("ld_a_ce", {31'd0, d0_ce_n}, 32'd0);
        chk("ld_a_wbwe", {31'd0, d0_wb_we}, 32'd0);
        chk("ld_a_wbhold", {16'd0, d0_wb_data}, 32'h1234);
        chk("ld_a_ramaddr", {14'd0, d0_ram_addr}, 32'h00040);
        tick();
        chk("ld_d_stall", {31'd0, d0_stall}, 32'd0);
        chk("ld_d_oe", {31'd0, d0_oe_n}, 32'd0);
        chk("ld_d_wbwe", {31'd0, d0_wb_we}, 32'd0);
        tick();
        chk("ld_wbdata", {16'd0, d0_wb_data}, 32'hBEEF);
        chk("ld_wbaddr", {28'd0, d0_wb_addr}, 32'd5);
        chk("ld_wbwe", {31'd0, d0_wb_we}, 32'd1);
        chk("ld_done_oe", {31'd0, d0_oe_n}, 32'd1);

        // 4. SRAM store
        mem_re = 1'b0; mem_we = 1'b1; mem_addr = 16'h0100; mem_wdata = 16'h00A5; reg_addr = 4'd6;
        #1 chk("st_idle_stall", {31'd0, d0_stall}, 32'd1);
        tick();
        chk("st_a_ramaddr", {14'd0, d0_ram_addr}, 32'h00100);
        chk("st_a_wdata", {16'd0, d0_ram_wdata}, 32'h00A5);
        chk("st_a_ce", {31'd0, d0_ce_n}, 32'd0);
        chk("st_a_we_n", {31'd0, d0_we_n}, 32'd1);
        chk("st_a_oe", {31'd0, d0_oe_n}, 32'd1);
        chk("st_a_stall", {31'd0, d0_stall}, 32'd1);
        chk("st_a_wbwe", {31'd0, d0_wb_we}, 32'd0);
        tick();
        chk("st_p_we_n", {31'd0, d0_we_n}, 32'd0);
        chk("st_p_ce", {31'd0, d0_ce_n}, 32'd0);
        chk("st_p_stall", {31'd0, d0_stall}, 32'd0);
        chk("st_p_wbwe", {31'd0, d0_wb_we}, 32'd0);
        tick();
        chk("st_done_we_n", {31'd0, d0_we_n}, 32'd1);
        chk("st_done_ce", {31'd0, d0_ce_n}, 32'd1);
        chk("st_done_wbwe", {31'd0, d0_wb_we}, 32'd0);

        // 5. UART status load, then status store
        mem_we = 1'b0; mem_re = 1'b1; mem_addr = 16'hBF01;
        uart_dr = 1'b1; uart_tbre = 1'b0; reg_addr = 4'd9;
        #1 chk("stl_stall", {31'd0, d0_stall}, 32'd0);
        tick();
        chk("stl_wbdata", {16'd0, d0_wb_data}, 32'h0002);
        chk("stl_wbaddr", {28'd0, d0_wb_addr}, 32'd9);
        chk("stl_wbwe", {31'd0, d0_wb_we}, 32'd1);
        chk("stl_ce", {31'd0, d0_ce_n}, 32'd1);
        mem_re = 1'b0; mem_we = 1'b1;
        #1 chk("sts_stall", {31'd0, d0_stall}, 32'd0);
        tick();
        chk("sts_ce", {31'd0, d0_ce_n}, 32'd1);
        chk("sts_we_n", {31'd0, d0_we_n}, 32'd1);
        chk("sts_wbwe", {31'd0, d0_wb_we}, 32'd0);
        chk("sts_ramaddr_hold", {14'd0, d0_ram_addr}, 32'h00100);

        // top-of-space load: zero extension only
        mem_we = 1'b0; mem_re = 1'b1; mem_addr = 16'hFFFF; ram_data = 16'h5A5A; reg_addr = 4'd7;
        tick();
        chk("top_ramaddr", {14'd0, d0_ram_addr}, 32'h0FFFF);
        tick(); tick();
        chk("top_wbdata", {16'd0, d0_wb_data}, 32'h5A5A);
        chk("top_wbwe", {31'd0, d0_wb_we}, 32'd1);

        // 6. WAIT_CYC=3 instance: load latency and reset abort
        mem_re = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; mem_re = 1'b1; mem_addr = 16'h0200; ram_data = 16'h1111; reg_addr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("w3_addr_stall", {31'd0, d3_stall}, 32'd1);
            chk("w3_addr_oe", {31'd0, d3_oe_n}, 32'd0);
            chk("w3_addr_wbwe", {31'd0, d3_wb_we}, 32'd0);
        end
        tick();
        chk("w3_data_stall", {31'd0, d3_stall}, 32'd0);
        chk("w3_data_oe", {31'd0, d3_oe_n}, 32'd0);
        tick();
        chk("w3_wbdata", {16'd0, d3_wb_data}, 32'h1111);
        chk("w3_wbwe", {31'd0, d3_wb_we}, 32'd1);

        mem_addr = 16'h0300; ram_data = 16'h9999;
        tick(); tick();
        chk("abort_pre_oe", {31'd0, d3_oe_n}, 32'd0);
        rst = 1'b1;
        #1 chk("abort_rst_stall", {31'd0, d3_stall}, 32'd0);
        tick();
        chk("abort_ce", {31'd0, d3_ce_n}, 32'd1);
        chk("abort_oe", {31'd0, d3_oe_n}, 32'd1);
        chk("abort_wbwe", {31'd0, d3_wb_we}, 32'd0);
        chk("abort_wbdata", {16'd0, d3_wb_data}, 32'd0);

        // simultaneous load and store: store wins, no load write-back
        rst = 1'b0; mem_re = 1'b1; mem_we = 1'b1; mem_addr = 16'h0400; mem_wdata = 16'hC3C3;
        tick();
        chk("both_a_we_n", {31'd0, d0_we_n}, 32'd1);
        chk("both_a_oe", {31'd0, d0_oe_n}, 32'd1);
        chk("both_a_wdata", {16'd0, d0_ram_wdata}, 32'hC3C3);
        chk("both_a_wbwe", {31'd0, d0_wb_we}, 32'd0);
        tick();
        chk("both_p_we_n", {31'd0, d0_we_n}, 32'd0);
        chk("both_p_wbwe", {31'd0, d0_wb_we}, 32'd0);
        mem_re = 1'b0; mem_we = 1'b0;
        tick();
        chk("both_done_wbwe", {31'd0, d0_wb_we}, 32'd0);
        chk("both_done_wbdata", {16'd0, d0_wb_data}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
